// File: rtl/response_scheduler_pkg.sv
// Shared definitions for the response scheduler.
// Holds the FSM state encoding, the arbiter grant encoding, the default
// message header bytes and a helper that slices the captured cycle count
// into bytes, most significant byte first.
package response_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PKT_TAG   = 3'd1,
    PKT_BODY  = 3'd2,
    CYC_TAG   = 3'd3,
    CYC_BYTES = 3'd4
  } state_t;

  typedef enum logic {
    PACKET = 1'b0,
    CYCLES = 1'b1
  } grant_t;

  localparam logic [7:0] DEFAULT_PACKET_TAG = 8'h01;
  localparam logic [7:0] DEFAULT_CYCLES_TAG = 8'h02;

  // Index 0 selects the most significant byte.
  function automatic logic [7:0] count_byte(input logic [31:0] count,
                                            input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = count[31:24];
      2'd1:    b = count[23:16];
      2'd2:    b = count[15:8];
      default: b = count[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/response_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter.
// Ports:
//   clock, reset      - clock and asynchronous active-high reset
//   req_packet        - packet source requests the output stream
//   req_cycles        - cycle-report source requests the output stream
//   update            - commit the current grant into last_grant
//   grant_valid       - at least one requester is active
//   grant             - winning requester (alternates on a tie)
// last_grant resets to CYCLES so the first tie goes to packets.
module rr_arbiter2
  import response_scheduler_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   req_packet,
  input  logic   req_cycles,
  input  logic   update,
  output logic   grant_valid,
  output grant_t grant
);

  grant_t last_grant;

  always_comb begin
    grant_valid = req_packet | req_cycles;
    grant       = PACKET;
    if (req_packet && req_cycles) begin
      grant = (last_grant == PACKET) ? CYCLES : PACKET;
    end else if (req_cycles) begin
      grant = CYCLES;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= CYCLES;
    end else if (update && grant_valid) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/response_scheduler.sv
// response_scheduler: merges processor-result packets and clock-cycle
// reports into one outgoing byte stream without interleaving messages.
// Each message is a header tag followed by its body; a packet body is passed
// through with zero latency, a cycle report is the captured 32-bit count
// sent MSB first. At least one IDLE cycle separates messages.
// Ports:
//   clock, reset                    - clock, asynchronous active-high reset
//   packet_data/valid/last, _ready  - processor-result packet byte stream
//   clock_cycles/_valid, _ready     - cycle count of the last processor run
//   out_data/valid/last, out_ready  - byte stream to the packet constructor
module response_scheduler
  import response_scheduler_pkg::*;
#(
  parameter logic [7:0] PACKET_TAG = DEFAULT_PACKET_TAG,
  parameter logic [7:0] CYCLES_TAG = DEFAULT_CYCLES_TAG
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  packet_data,
  input  logic        packet_valid,
  output logic        packet_ready,
  input  logic        packet_last,
  input  logic [31:0] clock_cycles,
  input  logic        clock_cycles_valid,
  output logic        clock_cycles_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_count_q, pend_count_d;

  logic        grant_valid;
  grant_t      grant;
  logic        cyc_req;
  logic        cyc_grant;

  // A cycle report offered while the stream is busy (or while losing a tie)
  // is remembered here so a single-cycle valid pulse is still served at the
  // next IDLE arbitration.
  assign cyc_req = clock_cycles_valid | pend_q;

  rr_arbiter2 u_arbiter (
    .clock       (clock),
    .reset       (reset),
    .req_packet  (packet_valid),
    .req_cycles  (cyc_req),
    .update      (state_q == IDLE),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    cyc_grant    = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = '0;
    packet_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          if (grant == PACKET) begin
            state_d = PKT_TAG;
          end else begin
            state_d   = CYC_TAG;
            cyc_grant = 1'b1;
            count_d   = clock_cycles_valid ? clock_cycles : pend_count_q;
          end
        end
      end

      PKT_TAG: begin
        out_valid = 1'b1;
        out_data  = PACKET_TAG;
        if (out_ready) state_d = PKT_BODY;
      end

      PKT_BODY: begin
        out_data     = packet_data;
        out_valid    = packet_valid;
        out_last     = packet_last;
        packet_ready = out_ready;
        if (packet_valid && out_ready && packet_last) state_d = IDLE;
      end

      CYC_TAG: begin
        out_valid = 1'b1;
        out_data  = CYCLES_TAG;
        if (out_ready) state_d = CYC_BYTES;
      end

      CYC_BYTES: begin
        out_valid = 1'b1;
        out_data  = count_byte(count_q, idx_q);
        out_last  = (idx_q == 2'd3);
        if (out_ready) begin
          if (idx_q == 2'd3) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_d       = pend_q;
    pend_count_d = pend_count_q;
    if (cyc_grant) begin
      pend_d = 1'b0;
    end else if (clock_cycles_valid) begin
      pend_d       = 1'b1;
      pend_count_d = clock_cycles;
    end
  end

  assign clock_cycles_ready = cyc_grant & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      pend_q       <= 1'b0;
      pend_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      pend_count_q <= pend_count_d;
    end
  end

endmodule
